// File: rtl/gb_video_pkg.sv
// Shared Game Boy video constants, shade type, palette and address helpers.
// Used by the frame store and its block-RAM wrapper.
package gb_video_pkg;

    localparam int GB_WIDTH  = 160;
    localparam int GB_HEIGHT = 144;
    localparam int FB_DEPTH  = GB_WIDTH * GB_HEIGHT;
    localparam int FB_AW     = 15;

    localparam logic [23:0] PAL0 = 24'h9BBC0F;
    localparam logic [23:0] PAL1 = 24'h8BAC0F;
    localparam logic [23:0] PAL2 = 24'h306230;
    localparam logic [23:0] PAL3 = 24'h0F380F;

    typedef logic [1:0] shade_t;

    typedef enum logic {
        FB_IDLE,
        FB_PENDING
    } fb_state_t;

    // Linear pixel offset; the 160-wide case is two shifts and an add.
    function automatic logic [FB_AW-1:0] fb_offset(
        input logic [11:0] yy,
        input logic [11:0] xx
    );
        logic [18:0] sum;
        if (GB_WIDTH == 160) begin
            sum = {yy, 7'b0} + {2'b0, yy, 5'b0} + {7'b0, xx};
        end else begin
            sum = 19'(int'(yy) * GB_WIDTH + int'(xx));
        end
        return sum[FB_AW-1:0];
    endfunction

    function automatic logic [23:0] pal_rgb(input shade_t s);
        logic [23:0] c;
        unique case (s)
            2'd0:    c = PAL0;
            2'd1:    c = PAL1;
            2'd2:    c = PAL2;
            default: c = PAL3;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gb_fb_ram.sv
// Two-bank shade store: one write port, one registered read port.
// The address MSB picks the bank; no reset so it maps onto block RAM.
module gb_fb_ram
    import gb_video_pkg::*;
(
    input  logic           clk_i,
    input  logic           we_i,
    input  logic [FB_AW:0] waddr_i,
    input  shade_t         wdata_i,
    input  logic           re_i,
    input  logic [FB_AW:0] raddr_i,
    output shade_t         rdata_o
);

    shade_t mem [0:1][0:FB_DEPTH-1];
    shade_t rdata_q;

    // Synchronous write and registered read, one access each per cycle.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i[FB_AW]][waddr_i[FB_AW-1:0]] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i[FB_AW]][raddr_i[FB_AW-1:0]];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/gb_framebuffer.sv
// Double-buffered 160x144 frame store feeding the HDMI stage.
// Swaps banks only at a display frame end; reads return RGB 2 cycles later.
module gb_framebuffer
    import gb_video_pkg::*;
(
    input  logic        clock25mhz,
    input  logic        resetn,
    input  logic        wr_start,
    input  logic        wr_valid,
    input  logic [1:0]  wr_shade,
    output logic        wr_ready,
    input  logic [11:0] x,
    input  logic [11:0] y,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        front_sel,
    output logic        frame_shown
);

    fb_state_t        state_q, state_d;
    logic [FB_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic             front_q, front_d;
    logic             have_q, have_d;
    logic             shown_q, shown_d;
    logic [11:0]      y_prev_q;
    logic             in_rng_q;
    logic [23:0]      rgb_q;

    logic             wr_en;
    logic [FB_AW-1:0] wr_off;
    logic             frame_end;
    logic             swap;
    logic             rd_bank;
    logic             rd_in;
    shade_t           rd_shade;

    // Write acceptance, frame-end detect and next-state for the swap FSM.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        front_d  = front_q;
        have_d   = have_q;
        wr_en    = wr_valid && (state_q == FB_IDLE);
        wr_off   = wr_start ? '0 : wr_ptr_q;
        frame_end = (y_prev_q == 12'(GB_HEIGHT - 1))
                 && (y == 12'd0);
        swap     = frame_end && (state_q == FB_PENDING);
        shown_d  = swap;
        if (wr_start) begin
            wr_ptr_d = wr_en ? FB_AW'(1) : '0;
        end else if (wr_en) begin
            if (wr_ptr_q == FB_AW'(FB_DEPTH - 1)) begin
                wr_ptr_d = '0;
                state_d  = FB_PENDING;
            end else begin
                wr_ptr_d = wr_ptr_q + FB_AW'(1);
            end
        end
        if (swap) begin
            front_d = !front_q;
            have_d  = 1'b1;
            state_d = FB_IDLE;
        end
    end

    // Control state registers.
    always_ff @(posedge clock25mhz or negedge resetn) begin
        if (!resetn) begin
            state_q  <= FB_IDLE;
            wr_ptr_q <= '0;
            front_q  <= 1'b0;
            have_q   <= 1'b0;
            shown_q  <= 1'b0;
            y_prev_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            front_q  <= front_d;
            have_q   <= have_d;
            shown_q  <= shown_d;
            y_prev_q <= y;
        end
    end

    // A read issued on the swap cycle already targets the new front bank.
    always_comb begin
        rd_bank = swap ? !front_q : front_q;
        rd_in   = (x < 12'(GB_WIDTH)) && (y < 12'(GB_HEIGHT));
    end

    gb_fb_ram u_ram (
        .clk_i   (clock25mhz),
        .we_i    (wr_en),
        .waddr_i ({!front_q, wr_off}),
        .wdata_i (wr_shade),
        .re_i    (rd_in),
        .raddr_i ({rd_bank, fb_offset(y, x)}),
        .rdata_o (rd_shade)
    );

    // Read pipeline: in-range flag alongside RAM data, then palette register.
    always_ff @(posedge clock25mhz or negedge resetn) begin
        if (!resetn) begin
            in_rng_q <= 1'b0;
            rgb_q    <= '0;
        end else begin
            in_rng_q <= rd_in;
            rgb_q    <= (in_rng_q && have_q) ? pal_rgb(rd_shade) : '0;
        end
    end

    assign wr_ready    = (state_q == FB_IDLE);
    assign front_sel   = front_q;
    assign frame_shown = shown_q;
    assign r           = rgb_q[23:16];
    assign g           = rgb_q[15:8];
    assign b           = rgb_q[7:0];

endmodule

// File: doc/gb_framebuffer.md
# gb_framebuffer

Double-buffered Game Boy frame store sitting directly upstream of the HDMI output stage. It accepts a 160×144 stream of 2-bit shades from the PPU pixel pipe, keeps a displayed (front) buffer and a filling (back) buffer, and swaps them only on a display frame boundary. It answers the HDMI stage's (x, y) pixel requests with palette-mapped 24-bit RGB at a fixed 2-cycle latency, so the HDMI stage runs with CYCLE_DELAY = 2.

## Interface
- WIDTH, 160, pixels per line
- HEIGHT, 144, lines per frame
- PAL0, 24'h9BBC0F, RGB for shade 0
- PAL1, 24'h8BAC0F, RGB for shade 1
- PAL2, 24'h306230, RGB for shade 2
- PAL3, 24'h0F380F, RGB for shade 3

- clock25mhz  in  1  the single clock; all logic on its rising edge
- resetn  in  1  asynchronous, active-low reset
- wr_start  in  1  one-cycle pulse marking the start of a PPU frame
- wr_valid  in  1  wr_shade carries a pixel this cycle
- wr_shade  in  2  pixel shade 0..3, raster order
- wr_ready  out  1  back buffer accepts pixels (= !swap_pending)
- x  in  12  requested display column from the HDMI stage
- y  in  12  requested display line from the HDMI stage
- r  out  8  red for the (x, y) presented 2 cycles earlier
- g  out  8  green, same timing
- b  out  8  blue, same timing
- front_sel  out  1  which RAM bank is currently displayed
- frame_shown  out  1  one-cycle pulse on each buffer swap

## Operation
- Write side: wr_ptr (15 bits, 0..WIDTH*HEIGHT-1) addresses back bank = !front_sel.
- wr_start: wr_ptr <= 0, any partial frame discarded. If wr_valid is also high that cycle, the pixel is written at address 0 and wr_ptr <= 1.
- wr_valid && wr_ready: write shade at wr_ptr, increment. Write at WIDTH*HEIGHT-1 sets swap_pending, wr_ptr <= 0.
- While swap_pending: wr_valid ignored, nothing written, wr_ptr held. wr_start still clears wr_ptr.
- Swap detect: registered y_prev. A transition y_prev == HEIGHT-1 to y == 0 is a display frame end.
- At frame end with swap_pending: front_sel toggles, swap_pending <= 0, have_frame <= 1, frame_shown pulses. At frame end without pending: no change.
- Read address is y*WIDTH + x, computed as (y<<7)+(y<<5)+x for WIDTH=160. The general WIDTH case uses a constant multiply.
- Out of range (x >= WIDTH or y >= HEIGHT): no RAM read enable; the output is forced to 0.
- Until the first swap (have_frame = 0), r/g/b = 0.

## Timing
- Reset: r=g=b=0, front_sel=0, wr_ready=1, frame_shown=0, wr_ptr=0, swap_pending=0, have_frame=0, y_prev=0. RAM contents are not reset.
- Read pipeline:
  - cycle 0: x, y sampled.
  - cycle 1: RAM output shade plus registered in-range flag.
  - cycle 2: {r,g,b} registered from the palette mux.
  - Latency is exactly 2, throughput is 1 per cycle.
- wr_ready falls the cycle after the last pixel is written. It rises the cycle after the swap.
- Swap and the final write in the same cycle: swap_pending sets after that edge, so the swap happens at the next frame end, never mid-frame.
- front_sel changes at the clock edge with y == 0. Reads in that cycle already use the new bank.
- Reset mid-frame: everything returns to reset values. The next wr_start begins a fresh frame.
- The reader never sees the back bank, so there is no tearing.

## Structure
- Package gb_video_pkg holds: GB_WIDTH = 160, GB_HEIGHT = 144, shade_t (2-bit), default palette constants, FB_DEPTH = GB_WIDTH*GB_HEIGHT.
- Sub-module gb_fb_ram: simple dual-port RAM, 2×FB_DEPTH × 2 bits, one write port and one registered read port.
  - Bank select is the address MSB.
  - It must infer block RAM.
- The top level holds the write pointer, swap FSM (IDLE/PENDING implied by swap_pending), address generation and palette pipeline.

## Test plan
- Reset with y=0, x=0: r/g/b = 0, wr_ready = 1, front_sel = 0. Reads return 0 before the first swap.
- Write a full frame with shade = (x+y)%4, then sweep y from 143 to 0:
  - front_sel becomes 1 and frame_shown pulses once.
  - (x=5, y=2) returns PAL3 = 9BBC0F→0F380F mapping 2 cycles later.
- After a complete frame, with no display frame end: wr_ready = 0. A further 100 wr_valid pixels leave the back bank unchanged, verified after the swap.
- wr_start after 500 pixels, then a full frame of shade 1: every in-range read returns PAL1 (8BAC0F) after the swap.
- x=160, y=10 and x=3, y=144: output 0 with 2-cycle latency. No change to in-range pixels at neighbouring addresses.
- Assert resetn low mid-frame for 3 cycles: all outputs return to reset values. A subsequent full frame and swap display correctly.
